// File: rtl/ram_arbiter_rr_pkg.sv
// Shared definitions for the frame-buffer RAM arbiter: default frame-buffer
// geometry, pixel-engine requester indices, lock FSM state type and a helper
// for sizing index registers.
package ram_arbiter_rr_pkg;

  // Frame buffer holds one 8-bit iteration count per pixel.
  localparam int FB_DW = 8;
  localparam int FB_MD = 1024;

  // Pixel engines sharing the frame-buffer port.
  localparam int NUM_ENGINES = 4;
  localparam int ENG0        = 0;
  localparam int ENG1        = 1;
  localparam int ENG2        = 2;
  localparam int ENG3        = 3;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  // Width of a register holding a requester index (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Rotate-priority one-hot picker: grants the first set req bit scanning
// ptr+1, ptr+2, ... modulo NR.
// Latency: combinational. Backpressure: none, pure function of req and ptr.
// Ports:
//   req  in  NR  request vector
//   ptr  in  PW  last granted index (lowest priority this cycle)
//   gnt  out NR  one-hot grant, all-zero when req is zero
//   idx  out PW  index of the granted bit (0 when no grant)
module ram_arbiter_rr_pick #(
  parameter int NR = 4,
  parameter int PW = 2
) (
  input  logic [NR-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NR-1:0] gnt,
  output logic [PW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // k runs 1..NR so ptr itself is scanned last.
    for (int k = 1; k <= NR; k++) begin
      if (!found && req[(int'(ptr) + k) % NR]) begin
        found                    = 1'b1;
        gnt[(int'(ptr) + k) % NR] = 1'b1;
        idx                      = PW'((int'(ptr) + k) % NR);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter_rr.sv
// Round-robin arbiter sharing one RAM port between NR requesters, with an
// optional bounded burst lock; one beat per cycle, registered RAM command.
// Latency: grant same cycle, RAM command next cycle, read data 2 cycles after grant.
// Backpressure: req_rdy is the grant; unselected requesters wait (worst case (NR-1)*BL cycles).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_vld/req_lock/req_we    per-requester valid, burst lock, write enable
//   req_adr/req_dat_w          packed per-requester address / write data
//   req_rdy                    one-hot grant (beat accepted on req_vld & req_rdy)
//   rsp_vld/rsp_dat_r          one-hot read return valid, shared read data
//   ram_we/ram_adr/ram_dat_w   registered RAM command
//   ram_dat_r                  RAM read data (1-cycle registered RAM)
module ram_arbiter_rr
  import ram_arbiter_rr_pkg::*;
#(
  parameter int NR = NUM_ENGINES,
  parameter int DW = FB_DW,
  parameter int MD = FB_MD,
  parameter int AW = $clog2(MD),
  parameter int BL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR-1:0]    req_vld,
  input  logic [NR-1:0]    req_lock,
  input  logic [NR-1:0]    req_we,
  input  logic [NR*AW-1:0] req_adr,
  input  logic [NR*DW-1:0] req_dat_w,
  output logic [NR-1:0]    req_rdy,
  output logic [NR-1:0]    rsp_vld,
  output logic [DW-1:0]    rsp_dat_r,
  output logic             ram_we,
  output logic [AW-1:0]    ram_adr,
  output logic [DW-1:0]    ram_dat_w,
  input  logic [DW-1:0]    ram_dat_r
);

  localparam int            PW      = idx_width(NR);
  localparam int            CW      = $clog2(BL + 1);
  localparam bit            LOCK_EN = (BL > 1);
  localparam logic [PW-1:0] PTR_RST = PW'(NR - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BL);

  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  lock_state_e   lk_st;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [NR-1:0] rd_tag1;
  logic [NR-1:0] rd_tag2;

  logic [NR-1:0] rr_gnt;
  logic [PW-1:0] rr_idx;

  logic          owner_hold;
  logic [NR-1:0] gnt;
  logic [PW-1:0] gidx;
  logic          acc;
  logic          sel_we;
  logic          sel_lock;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_dat;

  ram_arbiter_rr_pick #(
    .NR (NR),
    .PW (PW)
  ) u_pick (
    .req (req_vld),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Grant: a locked owner that is still requesting wins; otherwise round
  // robin. If the owner drops req_vld the rr pick is used in that same cycle,
  // and since ptr already equals owner the owner ranks last.
  always_comb begin
    owner_hold = (lk_st == LK_LOCKED) && req_vld[owner];
    gnt        = '0;
    gidx       = rr_idx;
    if (owner_hold) begin
      gnt[owner] = 1'b1;
      gidx       = owner;
    end else begin
      gnt = rr_gnt;
    end
    if (!rst_n) begin
      gnt = '0;
    end
    acc = |gnt;

    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_adr  = '0;
    sel_dat  = '0;
    for (int i = 0; i < NR; i++) begin
      if (gidx == PW'(i)) begin
        sel_we   = req_we[i];
        sel_lock = req_lock[i];
        sel_adr  = req_adr[i*AW +: AW];
        sel_dat  = req_dat_w[i*DW +: DW];
      end
    end
  end

  assign req_rdy = gnt;
  assign cnt_inc = cnt + 1'b1;

  // Rotate pointer and registered RAM command. Address and data hold on
  // idle cycles; only the write enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= PTR_RST;
      ram_we    <= 1'b0;
      ram_adr   <= '0;
      ram_dat_w <= '0;
    end else if (acc) begin
      ptr       <= gidx;
      ram_we    <= sel_we;
      ram_adr   <= sel_adr;
      ram_dat_w <= sel_dat;
    end else begin
      ram_we    <= 1'b0;
    end
  end

  // Burst lock FSM. cnt counts owner beats including the one that opened the
  // lock; the beat that brings cnt to BL is the final locked beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_st <= LK_IDLE;
      owner <= '0;
      cnt   <= '0;
    end else begin
      case (lk_st)
        LK_IDLE: begin
          if (acc && sel_lock && LOCK_EN) begin
            lk_st <= LK_LOCKED;
            owner <= gidx;
            cnt   <= CW'(1);
          end
        end
        LK_LOCKED: begin
          if (owner_hold) begin
            if (!sel_lock || (cnt_inc == CNT_MAX)) begin
              lk_st <= LK_IDLE;
              cnt   <= '0;
            end else begin
              cnt   <= cnt_inc;
            end
          end else if (acc && sel_lock && LOCK_EN) begin
            // Owner released; the requester picked by rr this cycle opens a new lock.
            owner <= gidx;
            cnt   <= CW'(1);
          end else begin
            lk_st <= LK_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          lk_st <= LK_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Read tag pipe: stage 1 lines up with the RAM command, stage 2 with the
  // RAM's registered read data. Reset clears tags so in-flight reads vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag1 <= '0;
      rd_tag2 <= '0;
    end else begin
      rd_tag1 <= (acc && !sel_we) ? gnt : '0;
      rd_tag2 <= rd_tag1;
    end
  end

  assign rsp_vld   = rd_tag2;
  assign rsp_dat_r = ram_dat_r;

endmodule
